// File: rtl/blood_pkg.sv
// rtl/blood_pkg.sv - shared constants and FSM state type for the blood sprite engine
package blood_pkg;

    localparam int SPR_DIM    = 64;
    localparam int SPR_ADDR_W = 6;
    localparam int COLOR_W    = 12;

    localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        PLAY = 2'd2
    } anim_state_t;

endpackage

// File: rtl/blood_anim_ctrl.sv
// rtl/blood_anim_ctrl.sv - animation FSM, frame/hold counters, position latch
// Optional BLOOD_RETRIG_EN: a trigger while busy re-latches the position and re-arms.
module blood_anim_ctrl
    import blood_pkg::*;
#(
    parameter int FRAMES     = 8,
    parameter int FRAME_HOLD = 4,
    parameter int XY_W       = 10,
    parameter int FW         = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            trigger,
    input  logic            frame_tick,
    input  logic [XY_W-1:0] pos_x,
    input  logic [XY_W-1:0] pos_y,
    output logic            busy,
    output logic            playing,
    output logic [FW-1:0]   frame,
    output logic [XY_W-1:0] px,
    output logic [XY_W-1:0] py
);

    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    anim_state_t   state, state_next;
    logic [HW-1:0] hold;
    logic          accept_trig;
    logic          hold_last;
    logic          frame_last;

`ifdef BLOOD_RETRIG_EN
    assign accept_trig = trigger;
`else
    assign accept_trig = trigger && (state == IDLE);
`endif

    assign hold_last  = (hold == HW'(FRAME_HOLD - 1));
    assign frame_last = (frame == FW'(FRAMES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = IDLE;
            ARM:     if (frame_tick) state_next = PLAY;
            PLAY:    if (frame_tick && hold_last && frame_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (accept_trig) state_next = ARM;
    end

    always_comb begin
        busy    = (state != IDLE);
        playing = (state == PLAY);
    end

    // Counters only move on frame_tick so rom_frame never changes mid-scan.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame <= '0;
            hold  <= '0;
            px    <= '0;
            py    <= '0;
        end else begin
            if (accept_trig) begin
                px <= pos_x;
                py <= pos_y;
            end
            if (frame_tick && !accept_trig) begin
                if (state == ARM) begin
                    frame <= '0;
                    hold  <= '0;
                end else if (state == PLAY) begin
                    if (!hold_last) begin
                        hold <= hold + 1'b1;
                    end else begin
                        hold  <= '0;
                        frame <= frame_last ? '0 : frame + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/blood_sprite_engine.sv
// rtl/blood_sprite_engine.sv - sprite box test, ROM addressing and 2-stage keyed pixel pipeline
module blood_sprite_engine
    import blood_pkg::*;
#(
    parameter int FRAMES     = 8,
    parameter int FRAME_HOLD = 4,
    parameter int XY_W       = 10,
    parameter int FW         = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  trigger,
    input  logic [XY_W-1:0]       pos_x,
    input  logic [XY_W-1:0]       pos_y,
    input  logic [XY_W-1:0]       x,
    input  logic [XY_W-1:0]       y,
    input  logic                  video_on,
    input  logic                  frame_tick,
    output logic [SPR_ADDR_W-1:0] rom_row,
    output logic [SPR_ADDR_W-1:0] rom_col,
    output logic [FW-1:0]         rom_frame,
    input  logic [COLOR_W-1:0]    rom_data,
    output logic                  busy,
    output logic                  pix_valid,
    output logic [COLOR_W-1:0]    pix_rgb
);

    logic                  playing;
    logic [XY_W-1:0]       px, py;
    logic [XY_W:0]         px_end, py_end;
    logic                  in_x, in_y, in_box;
    logic [SPR_ADDR_W-1:0] dx, dy;
    logic                  hit_d;
    logic                  pix_valid_next;

    blood_anim_ctrl #(
        .FRAMES     (FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .XY_W       (XY_W),
        .FW         (FW)
    ) u_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .trigger    (trigger),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .busy       (busy),
        .playing    (playing),
        .frame      (rom_frame),
        .px         (px),
        .py         (py)
    );

    // One extra bit so a sprite near the screen edge never wraps back to x=0.
    assign px_end = {1'b0, px} + (XY_W+1)'(SPR_DIM);
    assign py_end = {1'b0, py} + (XY_W+1)'(SPR_DIM);
    assign in_x   = ({1'b0, x} >= {1'b0, px}) && ({1'b0, x} < px_end);
    assign in_y   = ({1'b0, y} >= {1'b0, py}) && ({1'b0, y} < py_end);
    assign in_box = playing && video_on && in_x && in_y;

    assign dx      = x[SPR_ADDR_W-1:0] - px[SPR_ADDR_W-1:0];
    assign dy      = y[SPR_ADDR_W-1:0] - py[SPR_ADDR_W-1:0];
    assign rom_col = in_box ? dx : '0;
    assign rom_row = in_box ? dy : '0;

    assign pix_valid_next = hit_d && (rom_data != TRANSPARENT);

    // hit_d lines up with the ROM's registered-address latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_d     <= 1'b0;
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
        end else begin
            hit_d     <= in_box;
            pix_valid <= pix_valid_next;
            pix_rgb   <= pix_valid_next ? rom_data : '0;
        end
    end

endmodule
